ex_div_unit: RTL and testbench

- Iterative radix-2 restoring divider in the execute stage.
- Consumes operands and control from the ID/EX pipeline register for DIV/DIVU.
- Holds the pipeline through div_stall until quotient/remainder are ready, for the HI/LO write path.
- Supports signed and unsigned division, flush cancellation, and holding the result while downstream stalls persist.

---
 rtl/ex_div_unit.sv | 121 ++++++++++++
 tb/tb_ex_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Stalls the pipeline until HI/LO are ready, then holds them until acked.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             cancel,
    input  logic             result_ack,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, stateNext;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] remReg, quoReg;
    logic [WIDTH-1:0] divisor, dividendRaw;
    logic             signQ, signR, divZero;
    logic             start, lastStep;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] stepRem, stepQuo;
    logic [WIDTH-1:0] absA, absB;

    assign start    = div_startE & ~cancel;
    assign lastStep = (cnt == CW'(WIDTH - 1));

    assign absA = (div_signedE & src_aE[WIDTH-1]) ? -src_aE : src_aE;
    assign absB = (div_signedE & src_bE[WIDTH-1]) ? -src_bE : src_bE;

    // quoReg shifts dividend bits out the top while quotient bits enter below
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign stepRem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign stepQuo = {quoReg[WIDTH-2:0], ~diff[WIDTH]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        div_stall = 1'b0;
        div_done  = 1'b0;
        unique case (state)
            IDLE: begin
                div_stall = start;
                if (start) stateNext = BUSY;
            end
            BUSY: begin
                div_stall = 1'b1;
                if (lastStep) stateNext = DONE;
            end
            DONE: begin
                div_done = 1'b1;
                if (result_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (cancel || !resetn) begin
            stateNext = IDLE;
            div_stall = 1'b0;
            div_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            divisor     <= '0;
            dividendRaw <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            divZero     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (state == IDLE && start) begin
            cnt         <= '0;
            remReg      <= '0;
            quoReg      <= absA;
            divisor     <= absB;
            dividendRaw <= src_aE;
            signQ       <= div_signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
            signR       <= div_signedE & src_aE[WIDTH-1];
            divZero     <= (src_bE == '0);
        end else if (state == BUSY && !cancel) begin
            cnt    <= cnt + CW'(1);
            remReg <= stepRem;
            quoReg <= stepQuo;
            if (lastStep) begin
                if (divZero) begin
                    quotient  <= '1;
                    remainder <= dividendRaw;
                end else begin
                    quotient  <= signQ ? -stepQuo : stepQuo;
                    remainder <= signR ? -stepRem : stepRem;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Testbench for ex_div_unit: vector table, scoreboard queue and
// hand-written hold, cancel and reset sequences.
module tb_ex_div_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        div_startE;
    logic        div_signedE;
    logic [31:0] src_aE;
    logic [31:0] src_bE;
    logic        cancel;
    logic        result_ack;
    logic        div_stall;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    always #5 clk = ~clk;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_startE (div_startE),
        .div_signedE(div_signedE),
        .src_aE     (src_aE),
        .src_bE     (src_bE),
        .cancel     (cancel),
        .result_ack (result_ack),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runDiv(input string name, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input int hold);
        exp_t e;
        int   stalls = 0;
        int   lat = -1;
        @(posedge clk); #1;
        div_startE  = 1'b1;
        div_signedE = sgn;
        src_aE      = a;
        src_bE      = b;
        result_ack  = (hold == 0);
        sb.push_back('{q: q, r: r});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_done) begin
                lat = i;
                break;
            end
            if (div_stall) stalls++;
            @(posedge clk); #1;
        end
        chk({name, " latency"}, lat, 33);
        chk({name, " stall cycles"}, stalls, 33);
        if (lat < 0) begin
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({name, " stall at done"}, div_stall, 0);
        chk({name, " quotient"}, quotient, e.q);
        chk({name, " remainder"}, remainder, e.r);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({name, " hold done"}, div_done, 1);
            chk({name, " hold stall"}, div_stall, 0);
            chk({name, " hold quotient"}, quotient, e.q);
            chk({name, " hold remainder"}, remainder, e.r);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            result_ack = 1'b1;
            @(negedge clk);
            chk({name, " ack cycle done"}, div_done, 1);
        end
    endtask

    task automatic goIdle(input string name);
        @(posedge clk); #1;
        div_startE = 1'b0;
        @(negedge clk);
        chk({name, " idle stall"}, div_stall, 0);
        chk({name, " idle done"}, div_done, 0);
    endtask

    initial begin
        int doneSeen;
        vecs.push_back('{"divu 100/7", 0, 32'd100, 32'd7, 32'd14, 32'd2});
        vecs.push_back('{"div -7/2", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF});
        vecs.push_back('{"div 7/-2", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1});
        vecs.push_back('{"div ovf", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0});
        vecs.push_back('{"divu zero", 0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234});
        vecs.push_back('{"div zero", 1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9});
        vecs.push_back('{"divu max/1", 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{"divu max/16", 0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF});
        vecs.push_back('{"div -100/-7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE});
        vecs.push_back('{"div 0/5", 1, 32'd0, 32'd5, 32'd0, 32'd0});
        vecs.push_back('{"divu 5/9", 0, 32'd5, 32'd9, 32'd0, 32'd5});
        vecs.push_back('{"divu as signed", 0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1});

        resetn      = 1'b0;
        div_startE  = 1'b0;
        div_signedE = 1'b0;
        src_aE      = '0;
        src_bE      = '0;
        cancel      = 1'b0;
        result_ack  = 1'b1;
        #12;
        chk("reset done", div_done, 0);
        chk("reset stall", div_stall, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[k]) begin
            runDiv(vecs[k].name, vecs[k].sgn, vecs[k].a, vecs[k].b,
                   vecs[k].q, vecs[k].r, 0);
        end
        goIdle("table");

        runDiv("hold", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 3);
        goIdle("hold release");
        @(negedge clk);
        chk("hold no restart stall", div_stall, 0);
        chk("hold no restart done", div_done, 0);

        @(posedge clk); #1;
        div_startE  = 1'b1;
        div_signedE = 1'b0;
        src_aE      = 32'd1000;
        src_bE      = 32'd3;
        result_ack  = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        chk("cancel stall", div_stall, 0);
        chk("cancel done", div_done, 0);
        @(posedge clk); #1;
        cancel     = 1'b0;
        div_startE = 1'b0;
        @(negedge clk);
        chk("after cancel stall", div_stall, 0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done) doneSeen++;
        end
        chk("cancel never done", doneSeen, 0);
        runDiv("after cancel 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        goIdle("after cancel");

        @(posedge clk); #1;
        div_startE = 1'b1;
        cancel     = 1'b1;
        @(negedge clk);
        chk("idle cancel stall", div_stall, 0);
        @(posedge clk); #1;
        div_startE = 1'b0;
        cancel     = 1'b0;
        @(negedge clk);
        chk("idle cancel not busy", div_stall, 0);

        @(posedge clk); #1;
        div_startE  = 1'b1;
        div_signedE = 1'b0;
        src_aE      = 32'd500;
        src_bE      = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async reset quotient", quotient, 0);
        chk("async reset remainder", remainder, 0);
        chk("async reset stall", div_stall, 0);
        chk("async reset done", div_done, 0);
        div_startE = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        runDiv("b2b 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 0);
        runDiv("b2b 51/5", 1'b0, 32'd51, 32'd5, 32'd10, 32'd1, 0);
        goIdle("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
